alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Issue and capture stage that sits directly upstream of logic_operations and the arithmetic unit in the 8-bit ALU. It accepts one operation per valid/ready handshake, registers the operands and opcode, and drives the shared a/b/sel/enable buses for the required number of execute cycles. It then captures the selected 16-bit result plus status flags into an output register held under valid/ready backpressure.

Parameters:
MUL_LATENCY, 2, execute cycles for the multiply opcode (legal range 1..15); every other opcode executes in 1 cycle.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request
in_a  input  8  operand A
in_b  input  8  operand B
in_sel  input  3  opcode: 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 not-A, 111 reserved
op_a  output  8  registered operand A to execution units
op_b  output  8  registered operand B to execution units
op_sel  output  3  registered opcode to execution units
enable_logic  output  1  logic unit enable
enable_arith  output  1  arithmetic unit enable
logic_result  input  16  result from logic_operations
arith_result  input  16  result from arithmetic unit
out_valid  output  1  captured result valid
out_ready  input  1  consumer accepts result
out_result  output  16  captured result
out_zero  output  1  out_result == 0
out_ovf  output  1  out_result[15:8] != 0
out_err  output  1  reserved opcode was issued

Behaviour:
- One clock domain; asynchronous active-low reset on rst_n.
- Reset values: state IDLE; op_a, op_b, op_sel = 0; enable_logic, enable_arith = 0; out_valid = 0; out_result = 0; out_zero, out_ovf, out_err = 0; cycle counter = 0.
- in_ready = (state == IDLE). It is combinational from state, so it reads 1 while reset is asserted.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - On in_valid && in_ready at a rising edge, register in_a, in_b and in_sel into op_a, op_b and op_sel, then go to EXEC.
  - Load the counter with MUL_LATENCY-1 if in_sel == 010, otherwise 0.
  - in_valid without a handshake has no effect.
- EXEC:
  - enable_logic = 1 iff op_sel is in 011..110.
  - enable_arith = 1 iff op_sel is in 000..010.
  - Both enables are 0 for 111 and in every other state. They are decoded from registered op_sel and state and are glitch-free relative to clk.
  - Counter decrements once per cycle.
  - At the edge where counter == 0:
    - capture out_result = logic_result if enable_logic, else arith_result if enable_arith, else 0x0000;
    - out_err = (op_sel == 111);
    - out_zero and out_ovf are computed from the captured value;
    - out_valid <= 1; go to DONE.
- DONE:
  - out_result and all flags are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid <= 0 and go to IDLE. The flags and out_result keep their last value.
- Latency:
  - handshake at edge k → EXEC during cycles k+1 .. k+L, where L = 1, or MUL_LATENCY for mul;
  - out_valid high from cycle k+L+1;
  - earliest next accept is the edge after out_ready is sampled high.
- op_a, op_b and op_sel hold their values from EXEC through DONE and IDLE until the next accept. Downstream results are ignored outside EXEC.
- Reserved opcode 111: 1 EXEC cycle, no enable asserted, out_result = 0x0000, out_zero = 1, out_err = 1.
- Reset asserted in any state:
  - immediately returns all outputs to their reset values;
  - an in-flight operation is discarded, with no partial result;
  - after release the block is in IDLE with in_ready = 1.
- in_sel or operand changes while not in IDLE are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD … OP_RSVD (3-bit);
  - the state encoding IDLE/EXEC/DONE;
  - the result width constant (16) and operand width constant (8).
  - logic_operations and the arithmetic unit switch to these same opcode constants.
- One natural sub-module, alu_op_decode: combinational op_sel → {is_logic, is_arith, is_mul, is_rsvd}. It is reused by the controller and the bench scoreboard.

Test Plan:
- AND, in_a=0xF0, in_b=0x3C, in_sel=011, out_ready=1: enable_logic=1 for exactly 1 cycle; out_valid 2 cycles after accept; out_result=0x0030, zero=0, ovf=0, err=0.
- NOT, in_a=0x0F, in_sel=110: out_result=0x00F0. Then XOR with 0x55/0x55: out_result=0x0000, zero=1.
- MUL, MUL_LATENCY=3, in_a=0x12, in_b=0x10, arith stub returns 0x0120: enable_arith high for exactly 3 cycles; out_valid at accept+4; out_result=0x0120, ovf=1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid rises. out_result and flags stay stable and in_ready=0; a new request presented meanwhile is not accepted until the cycle after out_ready=1.
- Reserved opcode in_sel=111: no enable asserted; out_result=0x0000, zero=1, err=1.
- Reset mid-operation: assert rst_n=0 in the 2nd EXEC cycle of a MUL. All outputs go to reset values asynchronously; no out_valid appears after release; in_ready=1 and the next ADD 0x01+0x02 (stub 0x0003) completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: opcodes, issue FSM states, widths
// and the status-flag helpers used when a result is captured.
package alu_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic result_zero(input logic [RESULT_W-1:0] r);
        return (r == 16'h0000);
    endfunction

    // Overflow means the result no longer fits in the 8-bit operand width.
    function automatic logic result_ovf(input logic [RESULT_W-1:0] r);
        return (r[15:8] != 8'h00);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode classifier: tells which execution unit an opcode belongs to and
// whether it needs the multi-cycle multiply path.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] sel,
    output logic       is_logic,
    output logic       is_arith,
    output logic       is_mul,
    output logic       is_rsvd
);

    // Opcode class decode.
    always_comb begin
        is_logic = 1'b0;
        is_arith = 1'b0;
        is_mul   = 1'b0;
        is_rsvd  = 1'b0;
        case (sel)
            OP_ADD, OP_SUB: is_arith = 1'b1;
            OP_MUL: begin
                is_arith = 1'b1;
                is_mul   = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: is_logic = 1'b1;
            OP_RSVD: is_rsvd = 1'b1;
            default: is_rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture stage for the 8-bit ALU: accepts one operation, drives the
// execution units for its latency, then holds the captured result.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [2:0]  in_sel,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    output logic [2:0]  op_sel,
    output logic        enable_logic,
    output logic        enable_arith,
    input  logic [15:0] logic_result,
    input  logic [15:0] arith_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_err
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        accept_s;
    logic        finish_s;
    logic        release_s;
    logic [2:0]  sel_nxt_s;
    logic        dec_logic_s;
    logic        dec_arith_s;
    logic        dec_mul_s;
    logic        dec_rsvd_s;
    logic        en_logic_nxt_s;
    logic        en_arith_nxt_s;
    logic [15:0] capture_s;

    assign in_ready  = (state_r == IDLE);
    assign accept_s  = in_valid && in_ready;
    assign finish_s  = (state_r == EXEC) && (cnt_r == 4'd0);
    assign release_s = (state_r == DONE) && out_valid && out_ready;

    // Opcode that will be on op_sel next cycle; decoding it lets the enables be flops.
    always_comb begin
        if (accept_s) begin
            sel_nxt_s = in_sel;
        end else begin
            sel_nxt_s = op_sel;
        end
    end

    alu_op_decode u_decode (
        .sel      (sel_nxt_s),
        .is_logic (dec_logic_s),
        .is_arith (dec_arith_s),
        .is_mul   (dec_mul_s),
        .is_rsvd  (dec_rsvd_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: enables for the coming cycle and the result mux.
    always_comb begin
        en_logic_nxt_s = (state_nxt_s == EXEC) && dec_logic_s;
        en_arith_nxt_s = (state_nxt_s == EXEC) && dec_arith_s;
        if (enable_logic) begin
            capture_s = logic_result;
        end else if (enable_arith) begin
            capture_s = arith_result;
        end else begin
            capture_s = 16'h0000;
        end
    end

    // State register, execute counter and registered unit enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 4'd0;
            enable_logic <= 1'b0;
            enable_arith <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            enable_logic <= en_logic_nxt_s;
            enable_arith <= en_arith_nxt_s;
            if (accept_s) begin
                cnt_r <= dec_mul_s ? MUL_CNT : 4'd0;
            end else if ((state_r == EXEC) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Operand/opcode registers; they hold until the next accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a   <= 8'h00;
            op_b   <= 8'h00;
            op_sel <= 3'b000;
        end else if (accept_s) begin
            op_a   <= in_a;
            op_b   <= in_b;
            op_sel <= in_sel;
        end else begin
            op_a   <= op_a;
            op_b   <= op_b;
            op_sel <= op_sel;
        end
    end

    // Result capture on the last execute cycle, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= 16'h0000;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_err    <= 1'b0;
        end else if (finish_s) begin
            out_valid  <= 1'b1;
            out_result <= capture_s;
            out_zero   <= result_zero(capture_s);
            out_ovf    <= result_ovf(capture_s);
            out_err    <= dec_rsvd_s;
        end else if (release_s) begin
            out_valid  <= 1'b0;
        end else begin
            out_valid  <= out_valid;
        end
    end

endmodule
